// File: rtl/clk_cond_pkg.sv
// Shared constants and debouncer state encoding for the clock input conditioner.
package clk_cond_pkg;

   localparam int unsigned DEBOUNCE_DEFAULT   = 4;
   localparam int unsigned RATE_WIDTH_DEFAULT = 8;

   typedef enum logic {
      DB_STABLE  = 1'b0,
      DB_PENDING = 1'b1
   } db_state_t;

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer with a
// registered rising-edge pulse on the debounced level.
module debounce
   import clk_cond_pkg::*;
#(
   parameter int unsigned CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      raw,
   output logic      out,
   output logic      rise,
   output db_state_t state
);

   localparam int unsigned   CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

   logic          meta;
   logic          s;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          out_next;
   db_state_t     state_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta  <= 1'b0;
         s     <= 1'b0;
         out   <= 1'b0;
         rise  <= 1'b0;
         cnt   <= '0;
         state <= DB_STABLE;
      end else begin
         meta  <= raw;
         s     <= meta;
         out   <= out_next;
         rise  <= out_next & ~out;
         cnt   <= cnt_next;
         state <= state_next;
      end
   end

   // Any sample that agrees with the current output restarts the count.
   always_comb begin
      out_next = out;
      cnt_next = '0;
      if (s != out) begin
         if (cnt == LAST) begin
            out_next = s;
         end else begin
            cnt_next = cnt + CW'(1);
         end
      end
      state_next = (cnt_next == '0) ? DB_STABLE : DB_PENDING;
   end

endmodule

// File: rtl/clock_input_conditioner.sv
// Clock-stage front end: debounced push button and mode switch, plus a
// programmable half-period astable square wave with a rise pulse.
module clock_input_conditioner
   import clk_cond_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int unsigned RATE_WIDTH      = RATE_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  btn_raw,
   input  logic                  sel_raw,
   input  logic [RATE_WIDTH-1:0] rate,
   output logic                  push,
   output logic                  step,
   output logic                  select,
   output logic                  astable,
   output logic                  astable_rise
);

   // Debouncer states are brought out for probing but drive nothing here.
   db_state_t             btn_state_unused;
   db_state_t             sel_state_unused;
   logic                  sel_rise_unused;
   logic [RATE_WIDTH-1:0] div;
   logic                  wrap;

   debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_raw),
      .out   (push),
      .rise  (step),
      .state (btn_state_unused)
   );

   debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_sel_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (sel_raw),
      .out   (select),
      .rise  (sel_rise_unused),
      .state (sel_state_unused)
   );

   // >= rather than == so a rate lowered below the running count still wraps.
   assign wrap = (div >= rate);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div          <= '0;
         astable      <= 1'b0;
         astable_rise <= 1'b0;
      end else if (wrap) begin
         div          <= '0;
         astable      <= ~astable;
         astable_rise <= ~astable;
      end else begin
         div          <= div + RATE_WIDTH'(1);
         astable_rise <= 1'b0;
      end
   end

endmodule
